// File: rtl/sap_pkg.sv
// Shared FSM encoding, line count and one-hot helper for the 16-line demux.
// Single-cycle decode helper only; no state lives here.
package sap_pkg;

    localparam int NUM_LINES = 16;
    localparam int SEL_W     = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t BURST = 2'd1;
    localparam state_t DONE  = 2'd2;

    function automatic logic [NUM_LINES-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_LINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_line_reg.sv
// One held output line: WIDTH-bit register, synchronous clear wins over load.
// Value appears one cycle after en_i; no backpressure.
module demux_line_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/demux_16line_8bit.sv
// Routes one bus word into one of 16 held lines (single write or auto-incrementing burst).
// Write lands 1 cycle after the accepting beat; in_ready_o drops for the one DONE cycle.
// Optional DEMUX_BROADCAST_EN adds broadcast_i to write every line in one beat.
module demux_16line_8bit
    import sap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic [3:0]       sel_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             burst_i,
    input  logic [3:0]       burst_len_i,
`ifdef DEMUX_BROADCAST_EN
    input  logic             broadcast_i,
`endif
    output logic [WIDTH-1:0] out0_o,
    output logic [WIDTH-1:0] out1_o,
    output logic [WIDTH-1:0] out2_o,
    output logic [WIDTH-1:0] out3_o,
    output logic [WIDTH-1:0] out4_o,
    output logic [WIDTH-1:0] out5_o,
    output logic [WIDTH-1:0] out6_o,
    output logic [WIDTH-1:0] out7_o,
    output logic [WIDTH-1:0] out8_o,
    output logic [WIDTH-1:0] out9_o,
    output logic [WIDTH-1:0] out10_o,
    output logic [WIDTH-1:0] out11_o,
    output logic [WIDTH-1:0] out12_o,
    output logic [WIDTH-1:0] out13_o,
    output logic [WIDTH-1:0] out14_o,
    output logic [WIDTH-1:0] out15_o,
    output logic [15:0]      load_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LINES-1:0] load_q;
    logic [NUM_LINES-1:0] wr_en;
    logic                 accept;
    logic                 bcast;
    logic [WIDTH-1:0]     line_q [NUM_LINES];

`ifdef DEMUX_BROADCAST_EN
    assign bcast = broadcast_i;
`else
    assign bcast = 1'b0;
`endif

    assign accept = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            load_q  <= wr_en;
        end
    end

    // Next state, counters and the one-hot write decode share the same accept conditions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bcast) begin
                        wr_en   = '1;
                        state_d = DONE;
                    end else begin
                        wr_en = onehot(sel_i);
                        if (burst_i && (burst_len_i != 4'd0)) begin
                            ptr_d   = sel_i + 4'd1;
                            cnt_d   = burst_len_i;
                            state_d = BURST;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    wr_en = onehot(ptr_q);
                    ptr_d = ptr_q + 4'd1;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        if (((state_q == IDLE) || (state_q == BURST)) && !rst_i) begin
            in_ready_o = 1'b1;
        end
        if ((state_q == BURST) || (state_q == DONE)) begin
            busy_o = 1'b1;
        end
        if (state_q == DONE) begin
            done_o = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        demux_line_reg #(
            .WIDTH (WIDTH)
        ) u_line (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (wr_en[i]),
            .d_i   (in_i),
            .q_o   (line_q[i])
        );
    end

    assign load_o  = load_q;
    assign out0_o  = line_q[0];
    assign out1_o  = line_q[1];
    assign out2_o  = line_q[2];
    assign out3_o  = line_q[3];
    assign out4_o  = line_q[4];
    assign out5_o  = line_q[5];
    assign out6_o  = line_q[6];
    assign out7_o  = line_q[7];
    assign out8_o  = line_q[8];
    assign out9_o  = line_q[9];
    assign out10_o = line_q[10];
    assign out11_o = line_q[11];
    assign out12_o = line_q[12];
    assign out13_o = line_q[13];
    assign out14_o = line_q[14];
    assign out15_o = line_q[15];

endmodule

// File: tb/tb_demux_16line_8bit.sv
// Directed bench for demux_16line_8bit with a scoreboard of expected line writes.
module tb_demux_16line_8bit;

    logic        clk;
    logic        rst;
    logic [7:0]  in_dat;
    logic [3:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic        burst;
    logic [3:0]  burst_len;
    logic        broadcast;
    logic [7:0]  outs [16];
    logic [15:0] load;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] mask;
        logic [7:0]  data;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] exp_lines [16];
    int         n_chk;
    int         n_fail;

    demux_16line_8bit #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_i        (in_dat),
        .sel_i       (sel),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .burst_i     (burst),
        .burst_len_i (burst_len),
`ifdef DEMUX_BROADCAST_EN
        .broadcast_i (broadcast),
`endif
        .out0_o      (outs[0]),
        .out1_o      (outs[1]),
        .out2_o      (outs[2]),
        .out3_o      (outs[3]),
        .out4_o      (outs[4]),
        .out5_o      (outs[5]),
        .out6_o      (outs[6]),
        .out7_o      (outs[7]),
        .out8_o      (outs[8]),
        .out9_o      (outs[9]),
        .out10_o     (outs[10]),
        .out11_o     (outs[11]),
        .out12_o     (outs[12]),
        .out13_o     (outs[13]),
        .out14_o     (outs[14]),
        .out15_o     (outs[15]),
        .load_o      (load),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_lines(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_line%0d", tag, i), {24'd0, outs[i]}, {24'd0, exp_lines[i]});
        end
    endtask

    // Drive one beat (called #1 after a rising edge); mask is the line set it must write.
    task automatic beat(input string tag, input logic [7:0] d, input logic [3:0] s,
                        input logic b, input logic [3:0] bl, input logic bc,
                        input logic [15:0] mask);
        exp_t e;
        exp_t got;
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_dat    = d;
        sel       = s;
        burst     = b;
        burst_len = bl;
        broadcast = bc;
        in_valid  = 1'b1;
        e.mask = mask;
        e.data = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk({tag, "_load"}, {16'd0, load}, {16'd0, got.mask});
            for (int i = 0; i < 16; i++) begin
                if (got.mask[i]) begin
                    exp_lines[i] = got.data;
                    chk($sformatf("%s_out%0d", tag, i), {24'd0, outs[i]}, {24'd0, got.data});
                end
            end
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_load0"}, {16'd0, load}, 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_dat    = '0;
        sel       = '0;
        in_valid  = 1'b0;
        burst     = 1'b0;
        burst_len = '0;
        broadcast = 1'b0;
        for (int i = 0; i < 16; i++) exp_lines[i] = 8'h00;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk_all_lines("rst");
        chk("rst_load", {16'd0, load}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Single write
        beat("single", 8'hA5, 4'd3, 1'b0, 4'd0, 1'b0, 16'h0008);
        chk("single_done", {31'd0, done}, 32'd1);
        chk("single_ready0", {31'd0, in_ready}, 32'd0);
        chk("single_busy", {31'd0, busy}, 32'd1);
        idle_cycle("single_after");
        chk("single_ready1", {31'd0, in_ready}, 32'd1);
        chk("single_done0", {31'd0, done}, 32'd0);
        chk_all_lines("single");

        // burst=1 with burst_len=0 is a plain single write
        beat("len0", 8'h3C, 4'd6, 1'b1, 4'd0, 1'b0, 16'h0040);
        chk("len0_done", {31'd0, done}, 32'd1);
        idle_cycle("len0_after");

        // Wrapping burst; sel/burst on later beats must be ignored
        beat("wrap_b0", 8'h11, 4'd14, 1'b1, 4'd3, 1'b0, 16'h4000);
        chk("wrap_busy", {31'd0, busy}, 32'd1);
        beat("wrap_b1", 8'h22, 4'd2, 1'b0, 4'd9, 1'b0, 16'h8000);
        beat("wrap_b2", 8'h33, 4'd5, 1'b0, 4'd9, 1'b0, 16'h0001);
        chk("wrap_nodone", {31'd0, done}, 32'd0);
        beat("wrap_b3", 8'h44, 4'd7, 1'b1, 4'd9, 1'b0, 16'h0002);
        chk("wrap_done", {31'd0, done}, 32'd1);
        idle_cycle("wrap_after");
        chk("wrap_done0", {31'd0, done}, 32'd0);
        chk_all_lines("wrap");

        // Stalled burst: 3 idle cycles between beats 2 and 3
        beat("stall_b0", 8'hA1, 4'd5, 1'b1, 4'd3, 1'b0, 16'h0020);
        beat("stall_b1", 8'hA2, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            idle_cycle("stall_gap");
            chk("stall_busy", {31'd0, busy}, 32'd1);
            chk("stall_nodone", {31'd0, done}, 32'd0);
        end
        chk_all_lines("stall_gap");
        beat("stall_b2", 8'hA3, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0080);
        beat("stall_b3", 8'hA4, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0100);
        chk("stall_done", {31'd0, done}, 32'd1);
        idle_cycle("stall_after");
        chk_all_lines("stall");

        // Full 16-beat burst starting mid-range writes every line once
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  ln;
            logic [15:0] m;
            ln = 4'(7 + i);
            m  = 16'h0001 << ln;
            beat("full", 8'(8'h30 + i), 4'd7, 1'b1, 4'd15, 1'b0, m);
        end
        chk("full_done", {31'd0, done}, 32'd1);
        idle_cycle("full_after");
        chk_all_lines("full");

        // Reset after 2 of 5 beats
        beat("mid_b0", 8'hC0, 4'd9, 1'b1, 4'd4, 1'b0, 16'h0200);
        beat("mid_b1", 8'hC1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0400);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) exp_lines[i] = 8'h00;
        chk_all_lines("midrst");
        chk("midrst_load", {16'd0, load}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready1", {31'd0, in_ready}, 32'd1);
        idle_cycle("midrst_idle");
        chk("midrst_done_idle", {31'd0, done}, 32'd0);
        chk("midrst_busy_idle", {31'd0, busy}, 32'd0);
        beat("post_rst", 8'h77, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0001);
        chk("post_rst_done", {31'd0, done}, 32'd1);
        idle_cycle("post_rst_after");
        chk_all_lines("post_rst");

`ifdef DEMUX_BROADCAST_EN
        beat("bcast", 8'h5A, 4'd2, 1'b1, 4'd5, 1'b1, 16'hFFFF);
        chk("bcast_done", {31'd0, done}, 32'd1);
        chk_all_lines("bcast");
        broadcast = 1'b0;
        idle_cycle("bcast_after");
`endif

        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
